instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Fetch front-end that drives the 8-bit instruction address into the 9-bit, 256-deep combinational instruction ROM.
- Registers each returned word into a fetch/decode register.
- Owns the PC, the start/halt handshake with the testbench/top level, and redirection on absolute or relative branches resolved in decode.

Parameters:
- PC_W, 8, program-counter / ROM address width.
- INSTR_W, 9, instruction width.
- NOP_INSTR, 9'b000000000, word loaded into InstrOut on reset/squash.

Ports:
- CLK  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- Start  in  1  one-cycle pulse; begin execution at StartAddr.
- StartAddr  in  PC_W  initial PC for the program.
- Stall  in  1  hold PC and fetch register this cycle.
- Halt  in  1  decode signals halt instruction in InstrOut.
- BranchAbs  in  1  take absolute branch to BranchTarget.
- BranchRel  in  1  take relative branch: PCOut + signed BranchTarget.
- BranchTarget  in  PC_W  absolute address or two's-complement offset.
- InstrAddress  out  PC_W  combinational copy of PC to ROM.
- InstrIn  in  INSTR_W  ROM data for InstrAddress (same cycle).
- InstrOut  out  INSTR_W  registered instruction to decode.
- InstrValid  out  1  InstrOut holds a live instruction.
- PCOut  out  PC_W  address InstrOut was fetched from.
- Done  out  1  high while halted after a run.
- CycleCount  out  16  perf counter (see Optional Feature).
- InstrCount  out  16  perf counter (see Optional Feature).

Behaviour:
- One clock CLK. reset is synchronous and active-high: it is sampled only on the CLK rising edge.
- Reset values:
  - state=IDLE, PC=0, InstrOut=NOP_INSTR, InstrValid=0, PCOut=0, Done=0, counters=0.
  - reset overrides every other input.
- States:
  - IDLE: no fetch; InstrValid=0. Start -> PC<=StartAddr, RUN.
  - RUN: per edge, first matching rule wins:
    1. Stall: hold PC, InstrOut, InstrValid, PCOut. Branch and Halt are ignored; decode re-presents them next cycle.
    2. Halt (while InstrValid=1): -> HALTED, Done<=1, InstrValid<=0, InstrOut<=NOP_INSTR, PC held.
    3. BranchAbs or BranchRel (while InstrValid=1):
       - PC<=target; InstrValid<=0; InstrOut<=NOP_INSTR.
       - The wrong-path word fetched this cycle is squashed, so there is a 1-cycle bubble.
       - BranchAbs wins if both are asserted.
    4. Otherwise: InstrOut<=InstrIn, PCOut<=PC, InstrValid<=1, PC<=PC+1.
  - HALTED: hold everything; Done=1. Start -> PC<=StartAddr, Done<=0, InstrValid<=0, RUN.
  - Halt/Branch with InstrValid=0: ignored.
  - Start in RUN: ignored.
- Latency:
  - ROM read is combinational.
  - An instruction at address A appears on InstrOut one edge after PC==A.
  - The first valid instruction appears 2 edges after Start.
- Arithmetic:
  - All PC math is modulo 2^PC_W.
  - 8'hFF+1 -> 8'h00.
  - Relative target = PCOut + BranchTarget, where BranchTarget is treated as signed and the sum wraps.
- Reset mid-RUN: next edge returns to IDLE with all reset values; any in-flight instruction is dropped.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - CycleCount increments every edge in RUN, including stalled edges.
  - InstrCount increments on each rule-4 load.
  - Both saturate at 16'hFFFF.
  - Both clear on reset and on Start.
- Undefined: both ports are tied to 0 and no counter flops are generated.

Decomposition:
- Package fetch_pkg holds:
  - fetch_state_t enum {IDLE, RUN, HALTED}.
  - PC_W and INSTR_W localparams.
  - NOP_INSTR constant.
- One natural sub-module, next_pc_logic: combinational next-PC mux covering sequential, absolute, relative, start and hold.

Test Plan:
- Reset, then Start with StartAddr=8'h10:
  - InstrAddress=8'h10 after the first edge.
  - The next edge gives InstrOut=ROM[0x10], PCOut=8'h10, InstrValid=1.
  - The following edge gives PCOut=8'h11.
- Stall held 3 cycles mid-run at PC=8'h22: PC, InstrOut and PCOut are unchanged for 3 edges, then resume at 8'h22.
- BranchRel with PCOut=8'h05 and BranchTarget=8'hFC (-4):
  - Next edge: PC=8'h01, InstrValid=0.
  - Edge after: InstrOut=ROM[0x01], InstrValid=1.
- BranchAbs and BranchRel asserted together with BranchTarget=8'h40: PC=8'h40.
- StartAddr=8'hFE, no branches: PCOut sequence is FE, FF, 00, 01 (wrap).
- Halt at PCOut=8'h30:
  - Done=1 and InstrValid=0 next edge; state stays HALTED for 10 edges.
  - Start with StartAddr=8'h00 clears Done and refetches from 0.
  - With FETCH_PERF_CNT_EN defined, InstrCount equals the number of valid loads before Halt.
- reset asserted mid-RUN with Stall=1: next edge gives IDLE, InstrValid=0, PC=0, Done=0.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end (package fetch_pkg).
package fetch_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 9;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 9'b000000000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_next_pc_logic.sv
// Combinational next-PC selection: hold, start, sequential, absolute or relative branch.
import fetch_pkg::*;

module next_pc_logic (
  input  fetch_state_t    state,
  input  logic            start,
  input  logic [PC_W-1:0] start_addr,
  input  logic            stall,
  input  logic            halt,
  input  logic            branch_abs,
  input  logic            branch_rel,
  input  logic [PC_W-1:0] branch_target,
  input  logic            instr_valid,
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] pc_out,
  output logic [PC_W-1:0] next_pc
);

  always_comb begin
    next_pc = pc;
    case (state)
      IDLE, HALTED: begin
        if (start) next_pc = start_addr;
      end
      RUN: begin
        if (stall) begin
          next_pc = pc;
        end else if (instr_valid && halt) begin
          next_pc = pc;
        end else if (instr_valid && branch_abs) begin
          next_pc = branch_target;
        end else if (instr_valid && branch_rel) begin
          // Two's-complement offset: a plain modulo-2^PC_W add gives the signed result.
          next_pc = pc_out + branch_target;
        end else begin
          next_pc = pc + 1'b1;
        end
      end
      default: next_pc = pc;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch front-end: PC, fetch/decode register, start/halt control and branch redirect.
// Optional saturating perf counters are built when FETCH_PERF_CNT_EN is defined.
import fetch_pkg::*;

module instr_fetch (
  input  logic               CLK,
  input  logic               reset,
  input  logic               Start,
  input  logic [PC_W-1:0]    StartAddr,
  input  logic               Stall,
  input  logic               Halt,
  input  logic               BranchAbs,
  input  logic               BranchRel,
  input  logic [PC_W-1:0]    BranchTarget,
  output logic [PC_W-1:0]    InstrAddress,
  input  logic [INSTR_W-1:0] InstrIn,
  output logic [INSTR_W-1:0] InstrOut,
  output logic               InstrValid,
  output logic [PC_W-1:0]    PCOut,
  output logic               Done,
  output logic [15:0]        CycleCount,
  output logic [15:0]        InstrCount,
  output fetch_state_t       dbg_state
);

  fetch_state_t        state_q, state_n;
  logic [PC_W-1:0]     pc_q, pc_n;
  logic [INSTR_W-1:0]  instr_q, instr_n;
  logic                valid_q, valid_n;
  logic [PC_W-1:0]     pc_out_q, pc_out_n;
  logic                done_q, done_n;
  logic                start_accept;
  logic                load;

  assign start_accept = (state_q != RUN) && Start;
  assign load = (state_q == RUN) && !Stall &&
                !(valid_q && (Halt || BranchAbs || BranchRel));

  next_pc_logic u_next_pc (
    .state         (state_q),
    .start         (Start),
    .start_addr    (StartAddr),
    .stall         (Stall),
    .halt          (Halt),
    .branch_abs    (BranchAbs),
    .branch_rel    (BranchRel),
    .branch_target (BranchTarget),
    .instr_valid   (valid_q),
    .pc            (pc_q),
    .pc_out        (pc_out_q),
    .next_pc       (pc_n)
  );

  always_comb begin
    state_n  = state_q;
    instr_n  = instr_q;
    valid_n  = valid_q;
    pc_out_n = pc_out_q;
    done_n   = done_q;
    case (state_q)
      IDLE: begin
        valid_n = 1'b0;
        if (start_accept) state_n = RUN;
      end
      RUN: begin
        if (Stall) begin
          state_n = RUN;
        end else if (valid_q && Halt) begin
          state_n = HALTED;
          done_n  = 1'b1;
          valid_n = 1'b0;
          instr_n = NOP_INSTR;
        end else if (valid_q && (BranchAbs || BranchRel)) begin
          // The word fetched this cycle is on the wrong path: squash it.
          valid_n = 1'b0;
          instr_n = NOP_INSTR;
        end else if (load) begin
          instr_n  = InstrIn;
          pc_out_n = pc_q;
          valid_n  = 1'b1;
        end
      end
      HALTED: begin
        if (start_accept) begin
          state_n = RUN;
          done_n  = 1'b0;
          valid_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      instr_q  <= NOP_INSTR;
      valid_q  <= 1'b0;
      pc_out_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      pc_q     <= pc_n;
      instr_q  <= instr_n;
      valid_q  <= valid_n;
      pc_out_q <= pc_out_n;
      done_q   <= done_n;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] cycle_cnt_q;
  logic [15:0] instr_cnt_q;

  always_ff @(posedge CLK) begin
    if (reset || start_accept) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      if (state_q == RUN && cycle_cnt_q != 16'hFFFF) cycle_cnt_q <= cycle_cnt_q + 16'd1;
      if (load && instr_cnt_q != 16'hFFFF) instr_cnt_q <= instr_cnt_q + 16'd1;
    end
  end

  assign CycleCount = cycle_cnt_q;
  assign InstrCount = instr_cnt_q;
`else
  assign CycleCount = 16'd0;
  assign InstrCount = 16'd0;
`endif

  assign InstrAddress = pc_q;
  assign InstrOut     = instr_q;
  assign InstrValid   = valid_q;
  assign PCOut        = pc_out_q;
  assign Done         = done_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural combinational ROM.
import fetch_pkg::*;

module tb_instr_fetch;

  logic               CLK = 1'b0;
  logic               reset;
  logic               Start;
  logic [PC_W-1:0]    StartAddr;
  logic               Stall;
  logic               Halt;
  logic               BranchAbs;
  logic               BranchRel;
  logic [PC_W-1:0]    BranchTarget;
  logic [PC_W-1:0]    InstrAddress;
  logic [INSTR_W-1:0] InstrIn;
  logic [INSTR_W-1:0] InstrOut;
  logic               InstrValid;
  logic [PC_W-1:0]    PCOut;
  logic               Done;
  logic [15:0]        CycleCount;
  logic [15:0]        InstrCount;
  fetch_state_t       dbg_state;

  int vectors = 0;
  int miscompares = 0;
  logic [PC_W-1:0] exp_q[$];

  // clock / reset
  always #5 CLK = ~CLK;

  function automatic logic [INSTR_W-1:0] rom_word(input logic [PC_W-1:0] a);
    return {a[7] ^ a[0], a ^ 8'hA5};
  endfunction

  assign InstrIn = rom_word(InstrAddress);

  instr_fetch dut (
    .CLK          (CLK),
    .reset        (reset),
    .Start        (Start),
    .StartAddr    (StartAddr),
    .Stall        (Stall),
    .Halt         (Halt),
    .BranchAbs    (BranchAbs),
    .BranchRel    (BranchRel),
    .BranchTarget (BranchTarget),
    .InstrAddress (InstrAddress),
    .InstrIn      (InstrIn),
    .InstrOut     (InstrOut),
    .InstrValid   (InstrValid),
    .PCOut        (PCOut),
    .Done         (Done),
    .CycleCount   (CycleCount),
    .InstrCount   (InstrCount),
    .dbg_state    (dbg_state)
  );

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [PC_W-1:0] addr);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    Start = 1'b1;
    StartAddr = addr;
    tick();
    Start = 1'b0;
  endtask

  function automatic logic [15:0] exp_cnt(input logic [15:0] v);
`ifdef FETCH_PERF_CNT_EN
    return v;
`else
    return 16'd0 & v;
`endif
  endfunction

  initial begin
    reset = 1'b1; Start = 1'b0; StartAddr = '0; Stall = 1'b0; Halt = 1'b0;
    BranchAbs = 1'b0; BranchRel = 1'b0; BranchTarget = '0;
    tick();
    tick();
    chk("rst_state", 16'(dbg_state), 16'(IDLE));
    chk("rst_pc", 16'(InstrAddress), 16'h0000);
    chk("rst_instr", 16'(InstrOut), 16'(NOP_INSTR));
    chk("rst_valid", 16'(InstrValid), 16'h0000);
    chk("rst_pcout", 16'(PCOut), 16'h0000);
    chk("rst_done", 16'(Done), 16'h0000);
    chk("rst_cyc", CycleCount, 16'h0000);
    chk("rst_icnt", InstrCount, 16'h0000);

    // start at 0x10
    reset = 1'b0; Start = 1'b1; StartAddr = 8'h10;
    tick();
    Start = 1'b0;
    chk("start_pc", 16'(InstrAddress), 16'h0010);
    chk("start_valid", 16'(InstrValid), 16'h0000);
    tick();
    chk("first_instr", 16'(InstrOut), 16'(rom_word(8'h10)));
    chk("first_pcout", 16'(PCOut), 16'h0010);
    chk("first_valid", 16'(InstrValid), 16'h0001);
    tick();
    chk("second_pcout", 16'(PCOut), 16'h0011);

    // stall at PC=0x22, with halt and branch present but ignored
    do_start(8'h20);
    tick();
    tick();
    chk("pre_stall_pc", 16'(InstrAddress), 16'h0022);
    Stall = 1'b1; Halt = 1'b1; BranchAbs = 1'b1; BranchTarget = 8'h99;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", 16'(InstrAddress), 16'h0022);
      chk("stall_pcout", 16'(PCOut), 16'h0021);
      chk("stall_instr", 16'(InstrOut), 16'(rom_word(8'h21)));
      chk("stall_state", 16'(dbg_state), 16'(RUN));
    end
    Stall = 1'b0; Halt = 1'b0; BranchAbs = 1'b0;
    tick();
    chk("resume_pcout", 16'(PCOut), 16'h0022);
    chk("resume_instr", 16'(InstrOut), 16'(rom_word(8'h22)));
    chk("resume_pc", 16'(InstrAddress), 16'h0023);

    // relative branch backwards from PCOut=0x05
    do_start(8'h04);
    tick();
    tick();
    chk("rel_pre_pcout", 16'(PCOut), 16'h0005);
    BranchRel = 1'b1; BranchTarget = 8'hFC;
    tick();
    BranchRel = 1'b0;
    chk("rel_pc", 16'(InstrAddress), 16'h0001);
    chk("rel_bubble_valid", 16'(InstrValid), 16'h0000);
    chk("rel_bubble_instr", 16'(InstrOut), 16'(NOP_INSTR));
    tick();
    chk("rel_instr", 16'(InstrOut), 16'(rom_word(8'h01)));
    chk("rel_valid", 16'(InstrValid), 16'h0001);
    chk("rel_pcout", 16'(PCOut), 16'h0001);

    // branch while invalid is ignored; abs wins over rel
    do_start(8'h50);
    BranchAbs = 1'b1; BranchTarget = 8'h77;
    tick();
    chk("br_invalid_pc", 16'(InstrAddress), 16'h0051);
    chk("br_invalid_valid", 16'(InstrValid), 16'h0001);
    BranchRel = 1'b1; BranchTarget = 8'h40;
    tick();
    BranchAbs = 1'b0; BranchRel = 1'b0;
    chk("abs_wins_pc", 16'(InstrAddress), 16'h0040);
    chk("abs_wins_valid", 16'(InstrValid), 16'h0000);

    // PC wrap, scoreboarded through the expected queue
    exp_q.push_back(8'hFE);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    do_start(8'hFE);
    while (exp_q.size() > 0) begin
      logic [PC_W-1:0] e;
      tick();
      e = exp_q.pop_front();
      chk("wrap_pcout", 16'(PCOut), 16'(e));
      chk("wrap_instr", 16'(InstrOut), 16'(rom_word(e)));
    end

    // halt at PCOut=0x30, stay halted, restart from 0
    do_start(8'h2E);
    tick();
    tick();
    tick();
    chk("halt_pre_pcout", 16'(PCOut), 16'h0030);
    Halt = 1'b1;
    tick();
    Halt = 1'b0;
    chk("halt_done", 16'(Done), 16'h0001);
    chk("halt_valid", 16'(InstrValid), 16'h0000);
    chk("halt_instr", 16'(InstrOut), 16'(NOP_INSTR));
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("halted_state", 16'(dbg_state), 16'(HALTED));
      chk("halted_done", 16'(Done), 16'h0001);
    end
    chk("halt_icnt", InstrCount, exp_cnt(16'd3));
    chk("halt_cyc", CycleCount, exp_cnt(16'd4));
    Start = 1'b1; StartAddr = 8'h00;
    tick();
    Start = 1'b0;
    chk("restart_done", 16'(Done), 16'h0000);
    chk("restart_pc", 16'(InstrAddress), 16'h0000);
    chk("restart_icnt", InstrCount, 16'h0000);
    tick();
    chk("restart_instr", 16'(InstrOut), 16'(rom_word(8'h00)));
    chk("restart_valid", 16'(InstrValid), 16'h0001);

    // reset mid-run with stall
    Stall = 1'b1; reset = 1'b1;
    tick();
    Stall = 1'b0; reset = 1'b0;
    chk("midrst_state", 16'(dbg_state), 16'(IDLE));
    chk("midrst_valid", 16'(InstrValid), 16'h0000);
    chk("midrst_pc", 16'(InstrAddress), 16'h0000);
    chk("midrst_done", 16'(Done), 16'h0000);
    chk("midrst_pcout", 16'(PCOut), 16'h0000);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
